// File: rtl/if_id_skid_queue_if.sv
// ----------------------------------------------------------------------------
// if_id_skid_queue_if
//   Handshake and data bundle for the IF/ID boundary queue.
//   Fetch side : flush, in_valid/in_ready, instr_f, pc_f, pcplus4_f
//   Decode side: out_valid/out_ready, instr_d, pc_d, pcplus4_d, count
//   modport slave  : the queue itself (consumes fetch signals, drives decode signals)
//   modport master : the surrounding pipeline (drives fetch signals, consumes decode signals)
// Parameters
//   DATA_WIDTH : width of instr, PC and PC+4 fields
//   DEPTH      : queue entries (sets the width of count)
// ----------------------------------------------------------------------------
interface if_id_skid_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] instr_f;
    logic [DATA_WIDTH-1:0] pc_f;
    logic [DATA_WIDTH-1:0] pcplus4_f;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] instr_d;
    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] pcplus4_d;
    logic [CNT_W-1:0]      count;

    modport slave (
        input  flush, in_valid, instr_f, pc_f, pcplus4_f, out_ready,
        output in_ready, out_valid, instr_d, pc_d, pcplus4_d, count
    );

    modport master (
        output flush, in_valid, instr_f, pc_f, pcplus4_f, out_ready,
        input  in_ready, out_valid, instr_d, pc_d, pcplus4_d, count
    );
endinterface

// File: rtl/if_id_skid_queue.sv
// ----------------------------------------------------------------------------
// if_id_skid_queue
//   Elastic DEPTH-entry queue between fetch and decode carrying
//   {instr, PC, PC+4}. in_ready and out_valid come purely from registered
//   occupancy, so no combinational path crosses the boundary. An entry
//   pushed at one edge is visible on the outputs after that edge.
//   A synchronous flush empties the queue and wins over push/pop.
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active-low
//   bus   : if_id_skid_queue_if.slave (fetch handshake/data, decode
//           handshake/data, flush, occupancy count)
// Parameters
//   DATA_WIDTH : width of each data field (default 32)
//   DEPTH      : number of entries, power of two, >= 2 (default 2)
// Configuration macro
//   IFID_BUBBLE_NOP_EN : when defined, instr_d shows ADDI x0,x0,0 (0x13)
//                        whenever out_valid is 0; otherwise it shows 0.
// ----------------------------------------------------------------------------
module if_id_skid_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input logic               clk,
    input logic               rst_n,
    if_id_skid_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

`ifdef IFID_BUBBLE_NOP_EN
    localparam logic [DATA_WIDTH-1:0] BUBBLE_INSTR = DATA_WIDTH'(32'h0000_0013);
`else
    localparam logic [DATA_WIDTH-1:0] BUBBLE_INSTR = '0;
`endif

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pcplus4;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic   in_ready;
    logic   out_valid;
    logic   push;
    logic   pop;
    entry_t head;

    // Handshake flags depend on registered occupancy only.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    // NOTE: every variable gets its default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (bus.flush) begin
            // Redirect: drop everything, including this cycle's push/pop.
            // Storage is left alone; the pointers make it unreachable.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{instr:   bus.instr_f,
                                    pc:      bus.pc_f,
                                    pcplus4: bus.pcplus4_f};
                // DEPTH is a power of two, so the pointer wraps by overflow.
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: the storage array is reset as well so that every
            // entry starts at a known zero value after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Outputs show the head entry only while valid; otherwise a bubble.
    always_comb begin
        head = mem_q[rd_ptr_q];
        if (out_valid) begin
            bus.instr_d   = head.instr;
            bus.pc_d      = head.pc;
            bus.pcplus4_d = head.pcplus4;
        end else begin
            bus.instr_d   = BUBBLE_INSTR;
            bus.pc_d      = '0;
            bus.pcplus4_d = '0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.count     = count_q;

endmodule
